// File: rtl/um_lookup_pkg.sv
// Shared types and constants for the UM rule-lookup request arbiter.
package um_lookup_pkg;

    localparam int ID_W       = 6;
    localparam int ACT_W      = 16;
    localparam int LOOKUP_LAT = 2;
    localparam int MAX_REQ    = 8;

    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] grant;
    } lookup_tag_t;

    // Round-robin successor of idx in a ring of num entries.
    function automatic logic [3:0] rr_next(input logic [3:0] idx, input logic [3:0] num);
        logic [3:0] nxt;
        nxt = idx + 4'd1;
        return (nxt >= num) ? 4'd0 : nxt;
    endfunction

endpackage

// File: rtl/lookup_req_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the saved pointer.
module rr_arbiter
    import um_lookup_pkg::rr_next;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_any_o
);

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [IDX_W-1:0]   cand_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   idx_s;
    logic               found_s;

    // Priority search from ptr_q upward, wrapping modulo NUM_REQ.
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (en_i && !found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_s[cand_s] = 1'b1;
                idx_s           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            ptr_d = IDX_W'(rr_next(4'(idx_s), 4'(NUM_REQ)));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o     = grant_s;
    assign grant_idx_o = idx_s;
    assign grant_any_o = found_s;

endmodule

// File: rtl/lookup_req_arbiter.sv
// Shares one fixed-latency rule-lookup engine between NUM_REQ requesters and
// steers each returned action back to the requester that issued it.
module lookup_req_arbiter
    import um_lookup_pkg::lookup_tag_t;
    import um_lookup_pkg::MAX_REQ;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = um_lookup_pkg::ID_W,
    parameter int ACT_W   = um_lookup_pkg::ACT_W,
    parameter int LAT     = um_lookup_pkg::LOOKUP_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arb_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*ID_W-1:0] req_countid,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    countid_valid,
    output logic [ID_W-1:0]         countid,
    input  logic                    action_valid,
    input  logic [ACT_W-1:0]        action,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [ACT_W-1:0]        resp_action,
    output logic [31:0]             lookup_cnt,
    output logic                    err_sticky
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_any_s;

    logic               countid_valid_q, countid_valid_d;
    logic [ID_W-1:0]    countid_q, countid_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [ACT_W-1:0]   resp_action_q, resp_action_d;
    logic [31:0]        lookup_cnt_q, lookup_cnt_d;
    logic               err_q, err_d;
    lookup_tag_t        issue_tag_q, issue_tag_d;
    lookup_tag_t        tag_q [LAT];
    lookup_tag_t        out_tag_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_valid),
        .en_i        (arb_en),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s),
        .grant_any_o (grant_any_s)
    );

    // issue_tag_q rides with countid_valid; the LAT stages behind it line up with the engine result.
    assign out_tag_s = tag_q[LAT-1];

    // Next-state for issue, response steering, counter and error flag.
    always_comb begin
        issue_tag_d.valid = grant_any_s;
        issue_tag_d.grant = MAX_REQ'(grant_s);
        countid_valid_d   = grant_any_s;
        if (grant_any_s) begin
            countid_d = req_countid[grant_idx_s*ID_W +: ID_W];
        end else begin
            countid_d = countid_q;
        end
        lookup_cnt_d = lookup_cnt_q + (grant_any_s ? 32'd1 : 32'd0);
        if (action_valid && out_tag_s.valid) begin
            resp_valid_d  = out_tag_s.grant[NUM_REQ-1:0];
            resp_action_d = action;
        end else begin
            resp_valid_d  = '0;
            resp_action_d = resp_action_q;
        end
        err_d = err_q | (action_valid ^ out_tag_s.valid);
    end

    // State registers; reset drops all in-flight tags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            countid_valid_q <= 1'b0;
            countid_q       <= '0;
            resp_valid_q    <= '0;
            resp_action_q   <= '0;
            lookup_cnt_q    <= 32'd0;
            err_q           <= 1'b0;
            issue_tag_q     <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            countid_valid_q <= countid_valid_d;
            countid_q       <= countid_d;
            resp_valid_q    <= resp_valid_d;
            resp_action_q   <= resp_action_d;
            lookup_cnt_q    <= lookup_cnt_d;
            err_q           <= err_d;
            issue_tag_q     <= issue_tag_d;
            tag_q[0]        <= issue_tag_q;
            for (int k = 1; k < LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign req_ready     = grant_s;
    assign countid_valid = countid_valid_q;
    assign countid       = countid_q;
    assign resp_valid    = resp_valid_q;
    assign resp_action   = resp_action_q;
    assign lookup_cnt    = lookup_cnt_q;
    assign err_sticky    = err_q;

endmodule

// File: tb/tb_lookup_req_arbiter.sv
// Directed bench for lookup_req_arbiter with a 2-cycle engine model.
module tb_lookup_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        arb_en;
    logic [3:0]  req_valid;
    logic [23:0] req_countid;
    logic [3:0]  req_ready;
    logic        countid_valid;
    logic [5:0]  countid;
    logic        action_valid;
    logic [15:0] action;
    logic [3:0]  resp_valid;
    logic [15:0] resp_action;
    logic [31:0] lookup_cnt;
    logic        err_sticky;

    logic        eng_v0, eng_v1;
    logic [5:0]  eng_id0, eng_id1;
    logic        inject;

    typedef struct packed {
        logic [3:0] req;
        logic       en;
        logic [3:0] rdy;
    } vec_t;

    vec_t       vecs [32];
    logic [5:0] cids [4];
    int         total = 0;
    int         bad = 0;
    int         exp_cnt = 0;

    always #5 clk = ~clk;

    lookup_req_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .arb_en        (arb_en),
        .req_valid     (req_valid),
        .req_countid   (req_countid),
        .req_ready     (req_ready),
        .countid_valid (countid_valid),
        .countid       (countid),
        .action_valid  (action_valid),
        .action        (action),
        .resp_valid    (resp_valid),
        .resp_action   (resp_action),
        .lookup_cnt    (lookup_cnt),
        .err_sticky    (err_sticky)
    );

    function automatic logic [15:0] act_of(input logic [5:0] id);
        return 16'h122F + {10'd0, id};
    endfunction

    function automatic int oh2idx(input logic [3:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    // Engine model: result LAT=2 cycles after the issue strobe.
    always @(posedge clk) begin
        eng_v0  <= countid_valid;
        eng_id0 <= countid;
        eng_v1  <= eng_v0;
        eng_id1 <= eng_id0;
    end
    assign action_valid = eng_v1 | inject;
    assign action       = act_of(eng_id1);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rdy_at(input int t, input int nv);
        if (t < 0 || t >= nv) return 4'b0000;
        return vecs[t].rdy;
    endfunction

    task automatic run_vecs(input int nv);
        logic [3:0] prev_rdy;
        logic [3:0] old_rdy;
        for (int t = 0; t < nv + 5; t++) begin
            tick();
            if (t < nv) begin
                req_valid = vecs[t].req;
                arb_en    = vecs[t].en;
            end else begin
                req_valid = 4'b0000;
                arb_en    = 1'b1;
            end
            @(negedge clk);
            chk("arb_ready", 64'(req_ready), 64'(rdy_at(t, nv)));
            prev_rdy = rdy_at(t - 1, nv);
            chk("issue_valid", 64'(countid_valid), 64'(prev_rdy != 4'b0000));
            if (prev_rdy != 4'b0000) chk("issue_id", 64'(countid), 64'(cids[oh2idx(prev_rdy)]));
            old_rdy = rdy_at(t - 4, nv);
            chk("resp_valid", 64'(resp_valid), 64'(old_rdy));
            if (old_rdy != 4'b0000) chk("resp_action", 64'(resp_action), 64'(act_of(cids[oh2idx(old_rdy)])));
            if (rdy_at(t, nv) != 4'b0000) exp_cnt++;
        end
        chk("lookup_cnt", 64'(lookup_cnt), 64'(exp_cnt));
    endtask

    initial begin
        cids[0] = 6'd3;
        cids[1] = 6'd10;
        cids[2] = 6'd5;
        cids[3] = 6'd24;
        req_countid = {cids[3], cids[2], cids[1], cids[0]};
        reset = 1'b0;
        arb_en = 1'b1;
        req_valid = 4'b0000;
        inject = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_cv", 64'(countid_valid), 64'd0);
        chk("rst_cid", 64'(countid), 64'd0);
        chk("rst_rv", 64'(resp_valid), 64'd0);
        chk("rst_ra", 64'(resp_action), 64'd0);
        chk("rst_cnt", 64'(lookup_cnt), 64'd0);
        chk("rst_err", 64'(err_sticky), 64'd0);

        // Single request from requester 2
        tick();
        req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("single_cv", 64'(countid_valid), 64'd1);
        chk("single_cid", 64'(countid), 64'h05);
        for (int c = 2; c <= 5; c++) begin
            tick();
            @(negedge clk);
            chk("single_rv", 64'(resp_valid), (c == 4) ? 64'h4 : 64'h0);
            if (c >= 4) chk("single_ra", 64'(resp_action), 64'h1234);
        end
        chk("single_cnt", 64'(lookup_cnt), 64'd1);

        // Rotation table from ptr=0
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_cnt = 0;
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[5]  = '{4'b1010, 1'b1, 4'b0010};
        vecs[6]  = '{4'b1010, 1'b1, 4'b1000};
        vecs[7]  = '{4'b1010, 1'b0, 4'b0000};
        vecs[8]  = '{4'b0000, 1'b1, 4'b0000};
        vecs[9]  = '{4'b1010, 1'b1, 4'b0010};
        vecs[10] = '{4'b0001, 1'b1, 4'b0001};
        vecs[11] = '{4'b0001, 1'b1, 4'b0001};
        vecs[12] = '{4'b0110, 1'b1, 4'b0010};
        vecs[13] = '{4'b0110, 1'b1, 4'b0100};
        vecs[14] = '{4'b0110, 1'b1, 4'b0010};
        run_vecs(15);

        // arb_en low for 3 cycles with 2 lookups in flight (ptr=2 here)
        vecs[0] = '{4'b1111, 1'b1, 4'b0100};
        vecs[1] = '{4'b1111, 1'b1, 4'b1000};
        vecs[2] = '{4'b1111, 1'b0, 4'b0000};
        vecs[3] = '{4'b1111, 1'b0, 4'b0000};
        vecs[4] = '{4'b1111, 1'b0, 4'b0000};
        vecs[5] = '{4'b1111, 1'b1, 4'b0001};
        vecs[6] = '{4'b0000, 1'b1, 4'b0000};
        run_vecs(7);

        // Untagged engine result sets the sticky error
        chk("inj_err_pre", 64'(err_sticky), 64'd0);
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("inj_err", 64'(err_sticky), 64'd1);
            chk("inj_rv", 64'(resp_valid), 64'd0);
            tick();
        end

        // Reset with two tags in flight (ptr=1)
        req_valid = 4'b0011;
        @(negedge clk);
        chk("mr_ready0", 64'(req_ready), 64'h2);
        tick();
        @(negedge clk);
        chk("mr_ready1", 64'(req_ready), 64'h1);
        tick();
        req_valid = 4'b0000;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("mr_cv", 64'(countid_valid), 64'd0);
        chk("mr_cid", 64'(countid), 64'd0);
        chk("mr_rv", 64'(resp_valid), 64'd0);
        chk("mr_ra", 64'(resp_action), 64'd0);
        chk("mr_cnt", 64'(lookup_cnt), 64'd0);
        chk("mr_err", 64'(err_sticky), 64'd0);
        chk("mr_ptr0", 64'(req_ready), 64'h1);
        for (int c = 4; c <= 7; c++) begin
            tick();
            req_valid = 4'b0000;
            @(negedge clk);
            if (c == 4) chk("mr_cid_new", 64'(countid), 64'(cids[0]));
            chk("mr_err_late", 64'(err_sticky), 64'd1);
            chk("mr_rv_late", 64'(resp_valid), (c == 7) ? 64'h1 : 64'h0);
            if (c == 7) chk("mr_ra_late", 64'(resp_action), 64'(act_of(cids[0])));
        end

        // Counter wrap (ptr=1, requester 2 requests)
        force dut.lookup_cnt_q = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", 64'(lookup_cnt), 64'hFFFF_FFFF);
        tick();
        release dut.lookup_cnt_q;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("wrap_ready", 64'(req_ready), 64'h4);
        chk("wrap_hold", 64'(lookup_cnt), 64'hFFFF_FFFF);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("wrap_zero", 64'(lookup_cnt), 64'h0);
        repeat (5) tick();
        @(negedge clk);
        chk("err_stays", 64'(err_sticky), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lookup_req_arbiter.md
Name: lookup_req_arbiter

Overview:
- Shares one rule-lookup engine between NUM_REQ requesters.
- The engine takes a countid with a valid strobe and returns a 16-bit action exactly LAT cycles later.
- The block arbitrates requests round-robin, issues at most one lookup per cycle, and tracks each grant through a LAT-deep tag pipeline. It steers each returned action to the requester that issued it.
- Sits between the per-port flow classifiers and the rule-lookup stage in UM.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 6, countid width (rule RAM depth 64).
- ACT_W, 16, action width.
- LAT, 2, fixed engine latency in cycles from countid_valid to action_valid.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset, sampled on rising clk.
- arb_en  in  1  1 = grants allowed; 0 = freeze new grants (e.g. during rule RAM configuration); in-flight lookups still complete.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_countid  in  NUM_REQ*ID_W  packed countids; requester i occupies bits [i*ID_W +: ID_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational; transfer on req_valid[i] & req_ready[i].
- countid_valid  out  1  issue strobe to the lookup engine (registered).
- countid  out  ID_W  countid to the lookup engine (registered).
- action_valid  in  1  engine result strobe.
- action  in  ACT_W  engine result.
- resp_valid  out  NUM_REQ  one-hot result strobe, 1 cycle.
- resp_action  out  ACT_W  result data, valid with resp_valid.
- lookup_cnt  out  32  total issued lookups; wraps at 2^32.
- err_sticky  out  1  set on tag/strobe mismatch; cleared only by reset.

Behaviour:
- Reset (reset==0 at a clk edge) gives:
  - countid_valid=0, countid=0.
  - resp_valid=0, resp_action=0.
  - lookup_cnt=0, err_sticky=0.
  - RR pointer=0, tag pipeline cleared.
- Arbitration (combinational):
  - Search starts at index ptr and goes upward modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; at most one bit of req_ready is set.
  - req_ready is all-zero when arb_en=0.
- Pointer update: after a grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Requester rule: req_valid and req_countid must be held until ready. Dropping req_valid without a grant is legal, and no lookup is issued.
- Issue (one cycle after the grant edge):
  - countid_valid <= 1 and countid <= req_countid of the granted requester.
  - With no grant, countid_valid <= 0 and countid holds its previous value.
- Tag pipeline: LAT-stage shift register of {valid, one-hot grant}, loaded in step with countid_valid. Stage LAT-1 aligns with action_valid.
- Response (registered, 1 cycle after action_valid):
  - If action_valid=1 and the tag is valid: resp_valid <= tag one-hot, resp_action <= action.
  - Otherwise resp_valid <= 0 and resp_action holds.
- Total latency from grant edge to resp_valid is LAT+2 cycles; for LAT=2 that is 4.
- Throughput: one lookup per cycle, with back-to-back grants to different or the same requester.
- Mismatch: err_sticky <= 1 if action_valid=1 while the aligned tag is invalid, or action_valid=0 while the tag is valid. No resp_valid is emitted for an untagged action.
- lookup_cnt increments on every issued lookup and wraps 0xFFFFFFFF -> 0.
- arb_en falling mid-stream: the grant in the current cycle is suppressed if arb_en=0 that cycle. Already-issued tags drain and responses are delivered normally.
- Reset mid-operation: tags are discarded and pending responses dropped. An engine action_valid arriving after reset with an empty tag sets err_sticky. This is accepted behaviour; software re-reads err after the reset sequence.
- Simultaneous requests from all requesters: served in strict rotation, each waiting at most NUM_REQ-1 cycles.

Decomposition:
- Shared package (um_lookup_pkg):
  - constants ID_W=6, ACT_W=16, LOOKUP_LAT=2.
  - typedef lookup_tag_t {valid, grant one-hot}.
- One natural sub-module: rr_arbiter (req vector, enable, ptr update -> one-hot grant, grant index).
- The tag pipeline and response steering stay in the top module.

Test Plan:
- Single request: req_valid[2]=1, countid=0x05, engine returns 0x1234 at LAT=2 -> req_ready[2] for 1 cycle; countid_valid with countid=0x05 one cycle later; resp_valid=4'b0100 with resp_action=0x1234 4 cycles after the grant; lookup_cnt=1.
- All four requesting continuously, ptr=0 -> grants in order 0,1,2,3,0,…; each response steered to its own requester, in the same order; no idle issue cycles.
- arb_en dropped for 3 cycles with 2 lookups in flight -> req_ready=0 for those 3 cycles; both in-flight responses still delivered; arbitration resumes from the saved ptr.
- Engine model injects action_valid with no issued lookup -> err_sticky=1, no resp_valid; err_sticky stays 1 until reset.
- Reset asserted for 1 cycle with 2 tags in flight -> all outputs 0 on the next cycle; no resp_valid for the dropped lookups; ptr=0.
- lookup_cnt preloaded to 0xFFFFFFFF via force, one issue -> 0x00000000.
